// File: rtl/prog_mem_arbiter_pkg.sv
// ============================================================================
// Module : mcx_pkg
// Shared MCX program-line layout, opcodes and arbiter grant kinds.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mcx_pkg;

   localparam int LINE_W = 46;
   localparam int ADDR_W = 4;

   localparam int PC_LSB   = 42;
   localparam int COND_LSB = 40;
   localparam int INST_LSB = 36;
   localparam int ARG0_LSB = 24;
   localparam int ARG1_LSB = 12;
   localparam int ARG2_LSB = 0;
   localparam int ARG_W    = 12;

   localparam logic [3:0] STORE = 4'h1;
   localparam logic [3:0] JMP   = 4'h3;

   typedef enum logic [1:0] {
      GNT_IDLE  = 2'd0,
      GNT_LOAD  = 2'd1,
      GNT_FETCH = 2'd2
   } grant_e;

   function automatic logic [LINE_W-1:0] make_line(
      input logic [3:0]       pc,
      input logic [1:0]       cond,
      input logic [3:0]       inst,
      input logic [ARG_W-1:0] a0,
      input logic [ARG_W-1:0] a1,
      input logic [ARG_W-1:0] a2
   );
      return {pc, cond, inst, a0, a1, a2};
   endfunction

endpackage

`default_nettype wire

// File: rtl/prog_mem_arbiter_if.sv
// ============================================================================
// Module : prog_mem_arbiter_if
// Fetch, loader and memory buses of the program-memory arbiter.
// Optional req_lock signal present when PROG_ARB_LOCK_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface prog_mem_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 4,
   parameter int LINE_W  = 46
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        req_ready;
`ifdef PROG_ARB_LOCK_EN
   logic [NUM_REQ-1:0]        req_lock;
`endif
   logic                      resp_valid;
   logic [ID_W-1:0]           resp_id;
   logic [LINE_W-1:0]         resp_line;
   logic                      ld_valid;
   logic                      ld_ready;
   logic [ADDR_W-1:0]         ld_addr;
   logic [LINE_W-1:0]         ld_line;
   logic                      mem_en;
   logic                      mem_we;
   logic [ADDR_W-1:0]         mem_addr;
   logic [LINE_W-1:0]         mem_wdata;
   logic [LINE_W-1:0]         mem_rdata;

`ifdef PROG_ARB_LOCK_EN
   modport slave (
      input  req_valid, req_addr, req_lock, ld_valid, ld_addr, ld_line, mem_rdata,
      output req_ready, resp_valid, resp_id, resp_line, ld_ready,
             mem_en, mem_we, mem_addr, mem_wdata
   );
   modport master (
      output req_valid, req_addr, req_lock, ld_valid, ld_addr, ld_line, mem_rdata,
      input  req_ready, resp_valid, resp_id, resp_line, ld_ready,
             mem_en, mem_we, mem_addr, mem_wdata
   );
`else
   modport slave (
      input  req_valid, req_addr, ld_valid, ld_addr, ld_line, mem_rdata,
      output req_ready, resp_valid, resp_id, resp_line, ld_ready,
             mem_en, mem_we, mem_addr, mem_wdata
   );
   modport master (
      output req_valid, req_addr, ld_valid, ld_addr, ld_line, mem_rdata,
      input  req_ready, resp_valid, resp_id, resp_line, ld_ready,
             mem_en, mem_we, mem_addr, mem_wdata
   );
`endif

endinterface

`default_nettype wire

// File: rtl/prog_mem_arbiter_rr.sv
// ============================================================================
// Module : prog_arb_rr
// Combinational round-robin picker: first valid at or after ptr, wrapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module prog_arb_rr #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   int w_j;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      w_j   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_j = int'(ptr) + k;
         if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
         if (!any && valid[w_j]) begin
            any        = 1'b1;
            idx        = ID_W'(w_j);
            grant[w_j] = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/prog_mem_arbiter.sv
// ============================================================================
// Module : prog_mem_arbiter
// Single-port program memory arbiter: loader priority with burst bound,
// round-robin fetches, one-cycle tagged read response.
// Optional requester lock when PROG_ARB_LOCK_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module prog_mem_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int ADDR_W       = mcx_pkg::ADDR_W,
   parameter int LINE_W       = mcx_pkg::LINE_W,
   parameter int MAX_LD_BURST = 4
) (
   input  logic               clk,
   input  logic               rst,
   prog_mem_arbiter_if.slave  bus
);
   import mcx_pkg::*;

   localparam int c_ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int c_BC_W = $clog2(MAX_LD_BURST + 1);
   localparam logic [c_BC_W-1:0] c_BURST_MAX = c_BC_W'(MAX_LD_BURST);
   localparam logic [c_ID_W-1:0] c_LAST_ID   = c_ID_W'(NUM_REQ - 1);

   logic [c_ID_W-1:0]  r_rr_ptr;
   logic [c_BC_W-1:0]  r_burst_cnt;
   logic               r_rd_pend;
   logic [c_ID_W-1:0]  r_rd_id;

   logic [NUM_REQ-1:0] w_rr_grant;
   logic [c_ID_W-1:0]  w_rr_idx;
   logic               w_rr_any;
   logic               w_lock_hold;
   logic [c_ID_W-1:0]  w_lock_idx;
   grant_e             w_kind;
   logic [c_ID_W-1:0]  w_fetch_idx;

   prog_arb_rr #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (c_ID_W)
   ) u_rr (
      .valid (bus.req_valid),
      .ptr   (r_rr_ptr),
      .grant (w_rr_grant),
      .idx   (w_rr_idx),
      .any   (w_rr_any)
   );

`ifdef PROG_ARB_LOCK_EN
   logic              r_lock;
   logic [c_ID_W-1:0] r_lock_id;

   // Lock lapses by itself the first cycle the owner is not requesting.
   assign w_lock_hold = r_lock && bus.req_valid[r_lock_id];
   assign w_lock_idx  = r_lock_id;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lock    <= 1'b0;
         r_lock_id <= '0;
      end else if (w_kind == GNT_FETCH) begin
         r_lock    <= bus.req_lock[w_fetch_idx];
         r_lock_id <= w_fetch_idx;
      end else begin
         r_lock    <= 1'b0;
      end
   end
`else
   assign w_lock_hold = 1'b0;
   assign w_lock_idx  = '0;
`endif

   always_comb begin
      w_kind      = GNT_IDLE;
      w_fetch_idx = w_rr_idx;
      if (w_lock_hold) begin
         w_kind      = GNT_FETCH;
         w_fetch_idx = w_lock_idx;
      end else if (bus.ld_valid && ((r_burst_cnt != c_BURST_MAX) || !w_rr_any)) begin
         w_kind = GNT_LOAD;
      end else if (w_rr_any) begin
         w_kind = GNT_FETCH;
      end
      if (!rst) w_kind = GNT_IDLE;
   end

   assign bus.req_ready  = (w_kind == GNT_FETCH) ? (NUM_REQ'(1) << w_fetch_idx) : '0;
   assign bus.ld_ready   = (w_kind == GNT_LOAD);
   assign bus.mem_en     = (w_kind != GNT_IDLE);
   assign bus.mem_we     = (w_kind == GNT_LOAD);
   assign bus.mem_addr   = (w_kind == GNT_LOAD) ? bus.ld_addr
                                                : bus.req_addr[w_fetch_idx*ADDR_W +: ADDR_W];
   assign bus.mem_wdata  = bus.ld_line;
   assign bus.resp_valid = r_rd_pend;
   assign bus.resp_id    = r_rd_id;
   assign bus.resp_line  = bus.mem_rdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rr_ptr    <= '0;
         r_burst_cnt <= '0;
         r_rd_pend   <= 1'b0;
         r_rd_id     <= '0;
      end else begin
         r_rd_pend <= (w_kind == GNT_FETCH);
         case (w_kind)
            GNT_LOAD: begin
               if (r_burst_cnt != c_BURST_MAX) r_burst_cnt <= r_burst_cnt + 1'b1;
            end
            GNT_FETCH: begin
               r_burst_cnt <= '0;
               r_rd_id     <= w_fetch_idx;
               r_rr_ptr    <= (w_fetch_idx == c_LAST_ID) ? '0 : w_fetch_idx + 1'b1;
            end
            default: r_burst_cnt <= '0;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_prog_mem_arbiter.sv
// ============================================================================
// Module : tb_prog_mem_arbiter
// Self-checking bench for prog_mem_arbiter (lock sequence when PROG_ARB_LOCK_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prog_mem_arbiter;
   import mcx_pkg::*;

   localparam int N    = 2;
   localparam int AW   = 4;
   localparam int LW   = 46;
   localparam int MAXB = 4;

   typedef struct {
      bit           ldv;
      logic [3:0]   lda;
      logic [45:0]  ldl;
      logic [1:0]   rv;
      logic [3:0]   ra0;
      logic [3:0]   ra1;
      logic [1:0]   exp_rr;
      bit           exp_ld;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic init_req;
   always #5 clk = ~clk;

   prog_mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .LINE_W(LW)) bus ();

   prog_mem_arbiter #(
      .NUM_REQ(N), .ADDR_W(AW), .LINE_W(LW), .MAX_LD_BURST(MAXB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   function automatic logic [LW-1:0] init_line(input int i);
      return make_line(4'(i), 2'(i), STORE, 12'(i * 37 + 5), 12'(i * 101), 12'(~i));
   endfunction

   // Environment memory; separate from the reference copy ref_mem below.
   logic [LW-1:0] env_mem [16];
   always @(posedge clk) begin
      if (init_req) begin
         for (int i = 0; i < 16; i++) env_mem[i] <= init_line(i);
      end else if (bus.mem_en) begin
         if (bus.mem_we) env_mem[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata         <= env_mem[bus.mem_addr];
      end
   end

   int n_vec, n_err;
   logic [LW-1:0] ref_mem [16];
   int m_ptr, m_burst, m_lock_id, e_id;
   bit m_lock, e_rv;
   logic [LW-1:0] e_line;

   task chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task model_reset();
      m_ptr = 0; m_burst = 0; m_lock = 0; m_lock_id = 0; e_rv = 0; e_id = 0;
   endtask

   // One clock cycle: drive at negedge, check against the model, advance the model.
   task step(input bit ldv, input logic [3:0] lda, input logic [LW-1:0] ldl,
             input logic [1:0] rv, input logic [3:0] ra0, input logic [3:0] ra1,
             input logic [1:0] lk, output logic [1:0] o_rr, output logic o_ld);
      int kind, g;
      logic [3:0] addrs [2];
      @(negedge clk);
      rst          = 1'b1;
      bus.ld_valid = ldv;
      bus.ld_addr  = lda;
      bus.ld_line  = ldl;
      bus.req_valid = rv;
      bus.req_addr = {ra1, ra0};
`ifdef PROG_ARB_LOCK_EN
      bus.req_lock = lk;
`endif
      #1;
      addrs[0] = ra0; addrs[1] = ra1;
      kind = 0; g = 0;
      if (m_lock && rv[m_lock_id]) begin
         kind = 2; g = m_lock_id;
      end else if (ldv && (m_burst < MAXB || rv == 0)) begin
         kind = 1;
      end else begin
         for (int k = 0; k < N; k++)
            if (kind == 0 && rv[(m_ptr + k) % N]) begin kind = 2; g = (m_ptr + k) % N; end
      end
      chk("req_ready", 64'(bus.req_ready), (kind == 2) ? 64'(1 << g) : 64'd0);
      chk("ld_ready",  64'(bus.ld_ready), 64'(kind == 1));
      chk("mem_en",    64'(bus.mem_en), 64'(kind != 0));
      if (kind != 0) chk("mem_we", 64'(bus.mem_we), 64'(kind == 1));
      if (kind == 1) begin
         chk("ld_addr",  64'(bus.mem_addr), 64'(lda));
         chk("ld_wdata", 64'(bus.mem_wdata), 64'(ldl));
      end
      if (kind == 2) chk("fetch_addr", 64'(bus.mem_addr), 64'(addrs[g]));
      chk("resp_valid", 64'(bus.resp_valid), 64'(e_rv));
      if (e_rv) begin
         chk("resp_id",   64'(bus.resp_id), 64'(e_id));
         chk("resp_line", 64'(bus.resp_line), 64'(e_line));
      end
      o_rr = bus.req_ready;
      o_ld = bus.ld_ready;
      e_rv = (kind == 2);
      if (kind == 2) begin
         e_id    = g;
         e_line  = ref_mem[addrs[g]];
         m_ptr   = (g + 1) % N;
         m_burst = 0;
`ifdef PROG_ARB_LOCK_EN
         m_lock  = lk[g];
`else
         m_lock  = 1'b0;
`endif
         m_lock_id = g;
      end else begin
         m_lock = 1'b0;
         if (kind == 1) begin
            ref_mem[lda] = ldl;
            if (m_burst < MAXB) m_burst++;
         end else begin
            m_burst = 0;
         end
      end
   endtask

   vec_t tbl [16];
   logic [1:0] rr;
   logic ldr;

   initial begin
      n_vec = 0; n_err = 0;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_line(i);
      rst = 1'b0; init_req = 1'b1;
      bus.ld_valid = 1'b1; bus.ld_addr = 4'h1; bus.ld_line = '1;
      bus.req_valid = 2'b11; bus.req_addr = 8'h52;
`ifdef PROG_ARB_LOCK_EN
      bus.req_lock = 2'b00;
`endif

      for (int i = 0; i < 4; i++) begin
         tbl[i] = '{0, 4'h0, '0, 2'b11, 4'd2, 4'd5, (i % 2 == 0) ? 2'b01 : 2'b10, 0};
      end
      for (int i = 0; i < 12; i++) begin
         tbl[4 + i] = '{1, 4'(i + 8), make_line(4'(i), 2'd1, JMP, 12'(i), 12'hABC, 12'(i * 7)),
                        2'b10, 4'd0, 4'd9, (i % 5 == 4) ? 2'b10 : 2'b00, (i % 5 != 4)};
      end

      // Reset held with every valid asserted.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         if (i == 0) init_req = 1'b0;
         chk("rst_req_ready",  64'(bus.req_ready), 64'd0);
         chk("rst_ld_ready",   64'(bus.ld_ready), 64'd0);
         chk("rst_mem_en",     64'(bus.mem_en), 64'd0);
         chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      end
      model_reset();
      step(1, 4'h1, 46'h1234, 2'b11, 4'd2, 4'd5, 2'b00, rr, ldr);
      chk("rst_first_ld", 64'(ldr), 64'd1);

      // Round-robin then loader starvation bound.
      step(0, 4'h0, '0, 2'b00, 4'd0, 4'd0, 2'b00, rr, ldr);
      for (int i = 0; i < 16; i++) begin
         step(tbl[i].ldv, tbl[i].lda, tbl[i].ldl, tbl[i].rv, tbl[i].ra0, tbl[i].ra1,
              2'b00, rr, ldr);
         chk($sformatf("tbl%0d_rr", i), 64'(rr), 64'(tbl[i].exp_rr));
         chk($sformatf("tbl%0d_ld", i), 64'(ldr), 64'(tbl[i].exp_ld));
      end

      // Write in N, fetch in N+1, data in N+2.
      step(1, 4'd6, 46'h3_0000_0001_000, 2'b00, 4'd0, 4'd0, 2'b00, rr, ldr);
      step(0, 4'd0, '0, 2'b01, 4'd6, 4'd0, 2'b00, rr, ldr);
      step(0, 4'd0, '0, 2'b00, 4'd0, 4'd0, 2'b00, rr, ldr);
      chk("wr_rd_valid", 64'(bus.resp_valid), 64'd1);
      chk("wr_rd_line",  64'(bus.resp_line), 64'(46'h3_0000_0001_000));

      // Reset while a read is in flight.
      step(0, 4'd0, '0, 2'b01, 4'd3, 4'd0, 2'b00, rr, ldr);
      @(negedge clk);
      rst = 1'b0;
      bus.ld_valid = 1'b0; bus.req_valid = 2'b11;
      #1;
      chk("rst_drop_resp", 64'(bus.resp_valid), 64'd0);
      model_reset();
      step(0, 4'd0, '0, 2'b11, 4'd3, 4'd4, 2'b00, rr, ldr);
      chk("rst_ptr_zero", 64'(rr), 64'b01);

`ifdef PROG_ARB_LOCK_EN
      step(0, 4'd0, '0, 2'b00, 4'd0, 4'd0, 2'b00, rr, ldr);
      model_reset();
      step(0, 4'd0, '0, 2'b01, 4'd7, 4'd8, 2'b01, rr, ldr);
      chk("lock_g1", 64'(rr), 64'b01);
      step(1, 4'd2, 46'h55, 2'b11, 4'd7, 4'd8, 2'b01, rr, ldr);
      chk("lock_g2", 64'(rr), 64'b01);
      step(1, 4'd2, 46'h55, 2'b11, 4'd7, 4'd8, 2'b00, rr, ldr);
      chk("lock_g3", 64'(rr), 64'b01);
      step(1, 4'd2, 46'h55, 2'b11, 4'd7, 4'd8, 2'b00, rr, ldr);
      chk("lock_release_ld", 64'(ldr), 64'd1);
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic [1:0] lk;
         lk = 2'b00;
`ifdef PROG_ARB_LOCK_EN
         if ($urandom_range(3) == 0) lk = 2'($urandom);
`endif
         step(1'($urandom), 4'($urandom), LW'({$urandom, $urandom}), 2'($urandom),
              4'($urandom), 4'($urandom), lk, rr, ldr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/prog_mem_arbiter.md
# prog_mem_arbiter

Shares one single-port program memory between up to NUM_REQ MCX instruction-fetch requesters and one loader write port. Each cycle it grants at most one access. Loader writes take priority, bounded by a burst limit. Fetches are served round-robin, and read data returns one cycle after the grant, tagged with the requester ID. The block sits between the MCX cores' next-instruction address path and the `prog_mem` storage array.

## Interface
Parameters:
- NUM_REQ, 2: number of fetch requesters (2..8).
- ADDR_W, 4: program address width.
- LINE_W, 46: instruction line width (PC 4, cond 2, inst 4, args 3x12).
- MAX_LD_BURST, 4: consecutive loader grants allowed before one fetch slot is forced.

Ports:
- clk, in, 1: clock; all state on posedge.
- rst, in, 1: asynchronous, active-low reset.
- req_valid, in, NUM_REQ: fetch request per requester.
- req_addr, in, NUM_REQ*ADDR_W: packed fetch addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_ready, out, NUM_REQ: one-hot grant; a fetch is accepted when valid && ready.
- resp_valid, out, 1: read data valid.
- resp_id, out, clog2(NUM_REQ) (min 1): requester that owns resp_line.
- resp_line, out, LINE_W: fetched line.
- ld_valid / ld_ready, in / out, 1: loader write handshake.
- ld_addr, in, ADDR_W / ld_line, in, LINE_W: write address and data.
- mem_en, mem_we, out, 1: memory strobe and write enable.
- mem_addr, out, ADDR_W / mem_wdata, out, LINE_W: memory address and write data.
- mem_rdata, in, LINE_W: memory read data, valid the cycle after mem_en && !mem_we.

## Operation
Per-cycle arbitration is combinational from the inputs and registered state:
- **Loader grant.** The loader wins if ld_valid is high and burst_cnt < MAX_LD_BURST.
  - Drive mem_en=1, mem_we=1 and ld_ready=1.
  - burst_cnt increments, saturating at MAX_LD_BURST.
- **Fetch grant.** Otherwise, if any req_valid is high, grant the first requester at or after rr_ptr (wrapping at NUM_REQ-1 to 0).
  - Drive mem_en=1, mem_we=0 and req_ready[g]=1.
  - rr_ptr <= g+1, wrapping to 0.
  - burst_cnt <= 0.
- **Forced fetch slot.** When burst_cnt == MAX_LD_BURST and a fetch is pending, the loader is held off (ld_ready=0) and the fetch is granted.
- **No fetch pending.** If burst_cnt is saturated but no req_valid is high, the loader is granted anyway and burst_cnt stays saturated.
- **Idle.** mem_en=0, all ready outputs 0, burst_cnt <= 0.
- **Read response pipeline.** One stage: rd_pend <= fetch granted and rd_id <= g. resp_valid = rd_pend, resp_id = rd_id, resp_line = mem_rdata.
- **Write visibility.** A write committed in cycle N is visible to a fetch granted in cycle N+1.
- **Address out of range.** Address bits are passed through unchanged; the arbiter never masks them.

State summary: rr_ptr, burst_cnt (clog2(MAX_LD_BURST+1) bits), rd_pend, rd_id, plus the lock state when configured.

## Timing
- Reset (rst low, async): rr_ptr=0, burst_cnt=0, rd_pend=0, rd_id=0.
  - Hence resp_valid=0 and resp_id=0.
  - mem_en, mem_we, req_ready and ld_ready are forced 0 while rst is low.
- Reset asserted with a read in flight: the response is dropped and never emitted.
- Fetch latency: grant in cycle N, resp_valid in N+1.
- Throughput: one access per cycle; back-to-back fetches are allowed.
- All ready outputs are combinational from req_valid, ld_valid and state; the upstream side must not make valid depend on ready.
- Simultaneous loader and fetch: the loader wins unless the burst counter is saturated.
- Requester drops valid without a grant: no state change for that requester.

## Configuration
- PROG_ARB_LOCK_EN defined: adds an input port req_lock, NUM_REQ bits wide.
  - If the granted requester has req_lock[g]=1 at grant, it becomes the lock owner.
  - While locked, the owner is granted every cycle it is valid. Loader and other requesters are stalled, and the burst limit is ignored.
  - The lock releases on the first owner grant with req_lock=0, or on any cycle the owner's valid is 0.
  - The lock clears on reset.
- PROG_ARB_LOCK_EN undefined: no req_lock port and no lock state; behaviour exactly as in Operation.

## Structure
- Shared package mcx_pkg holds:
  - LINE_W=46 and ADDR_W=4.
  - Field offsets: PC [45:42], COND [41:40], INST [39:36], ARG0 [35:24], ARG1 [23:12], ARG2 [11:0].
  - Opcode constants JMP=4'h3 and STORE=4'h1.
- One sub-module, prog_arb_rr: combinational round-robin picker with inputs valid vector and pointer, outputs one-hot grant and index. It is reusable elsewhere.

## Test plan
- **Reset.** Hold rst low 3 cycles with all valids high -> all ready 0, resp_valid 0. Release -> first grant to the loader.
- **Round-robin.** NUM_REQ=2, both requesters valid at addresses 2 and 5 -> grants alternate 0,1,0,1. Each resp_valid arrives one cycle later with the correct resp_id and the memory lines at addresses 2 and 5.
- **Loader starvation bound.** ld_valid held for 10 writes while requester 1 is valid -> pattern of 4 writes, 1 fetch, 4 writes, 1 fetch. burst_cnt returns to 0 after each forced fetch.
- **Write-then-read.** Write 46'h3_0000_0001_000 to address 6 in cycle N; requester 0 fetches address 6 in N+1 -> resp_line equals that value in N+2.
- **Reset mid-flight.** Fetch granted in N, rst pulsed low during N+1 -> no resp_valid; rr_ptr=0 afterwards.
- **Lock (PROG_ARB_LOCK_EN).** Requester 0 locks for 3 fetches with the loader and requester 1 valid -> three consecutive grants to 0. The lock releases on the grant with req_lock=0, and the next grant goes to the loader.
